if_stage: RTL and testbench

Instruction-fetch stage of the five-stage LA32R pipeline, directly downstream of `pre_if_stage`. It latches the PC and exception info issued by pre-IF and collects the matching instruction from the inst-SRAM response (`data_ok`/`inst_sram_rdata`). It buffers the instruction while decode stalls, and discards responses that belong to flushed fetches. It then hands `{pc, inst, exception}` to decode.

---
 rtl/if_stage.sv | 154 +++++++++++++++
 tb/tb_if_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the five-stage LA32R pipeline.
//
// Takes one entry at a time from pre-IF (PC plus early exception info) and
// pairs it with its inst-SRAM response. While decode stalls, the response is
// held in a one-word buffer. Responses that belong to fetches cancelled by a
// redirect are counted and swallowed as they return. The result is presented
// to decode as {refill_ex, ecode, fs_ex, inst, pc}.
//
// Ports
//   clk, resetn          : clock; asynchronous active-low reset
//   ds_allowin           : decode can take an instruction this cycle
//   fs_allowin           : IF can take a pre-IF entry this cycle
//   ps_to_fs_valid/_bus  : pre-IF entry {s0_ex, s0_refill_ex, ecode, ps_ex, pc}
//   fs_flush             : redirect; cancels the entry currently held in IF
//   data_ok, inst_sram_rdata : inst-SRAM read response
//   fs_to_ds_valid/_bus  : entry to decode {refill_ex, ecode, fs_ex, inst, pc}
//   fs_wait_data         : valid non-exception entry still waiting for data
//
// Bus widths match PS_TO_FS_BUS_WD (41) and FS_TO_DS_BUS_WD (72).
// ---------------------------------------------------------------------------
module if_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    output logic        fs_allowin,
    input  logic        ps_to_fs_valid,
    input  logic [40:0] ps_to_fs_bus,
    input  logic        fs_flush,
    input  logic        data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic        fs_to_ds_valid,
    output logic [71:0] fs_to_ds_bus,
    output logic        fs_wait_data
);

    typedef struct packed {
        logic        s0_ex;
        logic        s0_refill_ex;
        logic [5:0]  ecode;
        logic        ps_ex;
        logic [31:0] pc;
    } ps_bus_t;

    typedef struct packed {
        logic        refill_ex;
        logic [5:0]  ecode;
        logic        fs_ex;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_bus_t;

    ps_bus_t     ps_in;
    ps_bus_t     fs_q;
    fs_bus_t     fs_out;

    logic        fs_valid;
    logic        inst_buf_valid;
    logic [31:0] inst_buf;
    logic [1:0]  drop_cnt;

    logic        fs_ex;
    logic        cur_ok;      // response belongs to the current entry
    logic        stale_ok;    // response belongs to a cancelled fetch
    logic        fs_ready_go;
    logic        accept;
    logic        retire;
    logic        buffer_en;
    logic        drop_inc;

    assign ps_in = ps_to_fs_bus;

    // A stage-0 translation fault always comes with ps_ex, but either bit
    // alone is enough to mark an entry that issued no SRAM request.
    assign fs_ex = fs_q.ps_ex | fs_q.s0_ex;

    assign cur_ok   = data_ok & (drop_cnt == 2'd0);
    assign stale_ok = data_ok & (drop_cnt != 2'd0);

    assign fs_wait_data   = fs_valid & ~fs_ex & ~inst_buf_valid;
    assign fs_ready_go    = fs_ex | inst_buf_valid | cur_ok;

    // A redirect empties the stage, so the redirected pre-IF entry may move
    // in during the same cycle as the flush.
    assign fs_allowin     = ~fs_valid | fs_flush | (fs_ready_go & ds_allowin);
    assign fs_to_ds_valid = fs_valid & fs_ready_go & ~fs_flush;

    assign accept    = ps_to_fs_valid & fs_allowin;
    assign retire    = fs_to_ds_valid & ds_allowin;
    assign buffer_en = fs_wait_data & cur_ok & ~ds_allowin & ~fs_flush;

    // A flushed entry that still has its request in flight leaves one stale
    // response behind. A response arriving in the flush cycle is the flushed
    // entry's own, so nothing is left to drop.
    assign drop_inc  = fs_flush & fs_wait_data & ~cur_ok;

    always_comb begin
        fs_out           = '0;
        fs_out.refill_ex = fs_q.s0_refill_ex;
        fs_out.ecode     = fs_q.ecode;
        fs_out.fs_ex     = fs_ex;
        fs_out.pc        = fs_q.pc;
        if (fs_ex)
            fs_out.inst = 32'h0;
        else if (inst_buf_valid)
            fs_out.inst = inst_buf;
        else
            fs_out.inst = inst_sram_rdata;
    end

    assign fs_to_ds_bus = fs_out;

    // Entry holder. A new accept takes priority over retire/flush clearing
    // fs_valid, since it refills the slot in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_valid <= 1'b0;
            fs_q     <= '0;
        end else if (accept) begin
            fs_valid <= 1'b1;
            fs_q     <= ps_in;
        end else if (fs_flush || retire) begin
            fs_valid <= 1'b0;
        end
    end

    // One-word buffer keeps the bus stable while decode stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_buf_valid <= 1'b0;
            inst_buf       <= 32'h0;
        end else if (accept || fs_flush || retire) begin
            inst_buf_valid <= 1'b0;
        end else if (buffer_en) begin
            inst_buf_valid <= 1'b1;
            inst_buf       <= inst_sram_rdata;
        end
    end

    // Count of stale responses still to swallow. The pipeline never has more
    // than two in flight, so the counter saturates at 2.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_cnt <= 2'd0;
        end else begin
            case ({drop_inc, stale_ok})
                2'b10:   if (drop_cnt != 2'd2) drop_cnt <= drop_cnt + 2'd1;
                2'b01:   drop_cnt <= drop_cnt - 2'd1;
                default: drop_cnt <= drop_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// Bench for if_stage. The reference keeps the fetch as a transaction-level
// picture: a queue of SRAM responses still in flight (each tagged as
// belonging to the live entry or to a cancelled one) plus a record of the
// entry held in IF. Directed scenarios come first, then random traffic.
// ---------------------------------------------------------------------------
module tb_if_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ds_allowin;
    logic        fs_allowin;
    logic        ps_to_fs_valid;
    logic [40:0] ps_to_fs_bus;
    logic        fs_flush;
    logic        data_ok;
    logic [31:0] inst_sram_rdata;
    logic        fs_to_ds_valid;
    logic [71:0] fs_to_ds_bus;
    logic        fs_wait_data;

    int n_chk = 0;
    int n_err = 0;

    // reference state
    bit          m_valid;
    bit          m_ex;
    bit          m_refill;
    bit [5:0]    m_ecode;
    bit [31:0]   m_pc;
    bit          m_have;
    bit [31:0]   m_inst;
    bit          resp_q[$];   // 1 = response of a cancelled fetch

    if_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ds_allowin      (ds_allowin),
        .fs_allowin      (fs_allowin),
        .ps_to_fs_valid  (ps_to_fs_valid),
        .ps_to_fs_bus    (ps_to_fs_bus),
        .fs_flush        (fs_flush),
        .data_ok         (data_ok),
        .inst_sram_rdata (inst_sram_rdata),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .fs_wait_data    (fs_wait_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [40:0] mkps(input logic s0, input logic rf, input logic [5:0] ec,
                                         input logic ex, input logic [31:0] pc);
        return {s0, rf, ec, ex, pc};
    endfunction

    function automatic int n_stale();
        int n = 0;
        foreach (resp_q[i]) if (resp_q[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_have = 0; m_ex = 0; m_refill = 0;
        m_ecode = 0; m_pc = 0; m_inst = 0;
        resp_q.delete();
    endtask

    // Compare DUT outputs against the reference for the inputs now applied,
    // then advance the reference by one cycle.
    task automatic model_eval();
        bit        front_cur, ready, efv, eallow, ewait, popped;
        bit [31:0] einst;
        front_cur = data_ok && resp_q.size() > 0 && !resp_q[0];
        ready  = m_ex || m_have || front_cur;
        efv    = m_valid && ready && !fs_flush;
        eallow = !m_valid || fs_flush || (ready && ds_allowin);
        ewait  = m_valid && !m_ex && !m_have;
        einst  = m_ex ? 32'h0 : (m_have ? m_inst : inst_sram_rdata);

        chk("drop_cnt", {70'h0, dut.drop_cnt}, 72'(n_stale()));
        chk("fs_to_ds_valid", {71'h0, fs_to_ds_valid}, {71'h0, efv});
        chk("fs_allowin", {71'h0, fs_allowin}, {71'h0, eallow});
        chk("fs_wait_data", {71'h0, fs_wait_data}, {71'h0, ewait});
        if (efv)
            chk("fs_to_ds_bus", fs_to_ds_bus, {m_refill, m_ecode, m_ex, einst, m_pc});

        // cancelled entry leaves its in-flight response behind as stale
        if (fs_flush && ewait && !front_cur && resp_q.size() > 0)
            resp_q[resp_q.size()-1] = 1'b1;
        if (data_ok && resp_q.size() > 0) begin
            popped = resp_q.pop_front();
            if (!popped && m_valid && !fs_flush && !ds_allowin) begin
                m_have = 1;
                m_inst = inst_sram_rdata;
            end
        end
        if (ps_to_fs_valid && eallow) begin
            m_valid  = 1;
            m_have   = 0;
            m_pc     = ps_to_fs_bus[31:0];
            m_ex     = ps_to_fs_bus[32] | ps_to_fs_bus[40];
            m_ecode  = ps_to_fs_bus[38:33];
            m_refill = ps_to_fs_bus[39];
            if (!m_ex) resp_q.push_back(1'b0);
        end else if (fs_flush || efv && ds_allowin) begin
            m_valid = 0;
            m_have  = 0;
        end
    endtask

    task automatic step(input logic psv, input logic [40:0] psb, input logic fl,
                        input logic dok, input logic [31:0] rd, input logic dsa);
        @(posedge clk); #1;
        ps_to_fs_valid  = psv;
        ps_to_fs_bus    = psb;
        fs_flush        = fl;
        data_ok         = dok;
        inst_sram_rdata = rd;
        ds_allowin      = dsa;
        #2;
        model_eval();
    endtask

    task automatic idle(input logic dsa);
        step(1'b0, 41'h0, 1'b0, 1'b0, 32'h0, dsa);
    endtask

    initial begin
        logic        psv, ex, fl, dok, dsa;
        logic [40:0] psb;

        resetn = 0; ps_to_fs_valid = 0; ps_to_fs_bus = 0; fs_flush = 0;
        data_ok = 0; inst_sram_rdata = 0; ds_allowin = 1;
        model_reset();
        #12;
        chk("rst fs_to_ds_valid", {71'h0, fs_to_ds_valid}, 72'h0);
        chk("rst fs_allowin", {71'h0, fs_allowin}, 72'h1);
        chk("rst fs_wait_data", {71'h0, fs_wait_data}, 72'h0);
        @(posedge clk); #1 resetn = 1;

        // basic fetch
        step(1, mkps(0, 0, 0, 0, 32'h1c000000), 0, 0, 0, 1);
        idle(1);
        step(0, 41'h0, 0, 1, 32'h02800c0c, 1);
        chk("basic bus", fs_to_ds_bus, {1'b0, 6'h0, 1'b0, 32'h02800c0c, 32'h1c000000});
        chk("basic valid", {71'h0, fs_to_ds_valid}, 72'h1);
        idle(1);
        chk("basic once", {71'h0, fs_to_ds_valid}, 72'h0);

        // decode stall
        step(1, mkps(0, 0, 0, 0, 32'h1c000000), 0, 0, 0, 1);
        idle(1);
        step(0, 41'h0, 0, 1, 32'h02800c0c, 0);
        idle(0);
        step(0, 41'h0, 0, 0, 32'hdeadbeef, 0);
        chk("stall allowin", {71'h0, fs_allowin}, 72'h0);
        chk("stall bus", fs_to_ds_bus, {1'b0, 6'h0, 1'b0, 32'h02800c0c, 32'h1c000000});
        step(0, 41'h0, 0, 0, 32'h12345678, 1);
        chk("stall release", fs_to_ds_bus, {1'b0, 6'h0, 1'b0, 32'h02800c0c, 32'h1c000000});
        chk("stall release valid", {71'h0, fs_to_ds_valid}, 72'h1);

        // flush while waiting, redirected entry accepted in the flush cycle
        step(1, mkps(0, 0, 0, 0, 32'h1c000004), 0, 0, 0, 1);
        step(1, mkps(0, 0, 0, 0, 32'h1c000100), 1, 0, 0, 1);
        step(0, 41'h0, 0, 1, 32'hAAAAAAAA, 1);
        chk("flush stale dropped", {71'h0, fs_to_ds_valid}, 72'h0);
        chk("flush drop_cnt 1", {70'h0, dut.drop_cnt}, 72'h1);
        idle(1);
        chk("flush drop_cnt 0", {70'h0, dut.drop_cnt}, 72'h0);
        step(0, 41'h0, 0, 1, 32'h0, 1);
        chk("flush new bus", fs_to_ds_bus, {1'b0, 6'h0, 1'b0, 32'h0, 32'h1c000100});
        chk("flush new valid", {71'h0, fs_to_ds_valid}, 72'h1);

        // flush coinciding with data_ok
        step(1, mkps(0, 0, 0, 0, 32'h1c000200), 0, 0, 0, 1);
        step(0, 41'h0, 1, 1, 32'h55555555, 1);
        chk("flush+dok valid", {71'h0, fs_to_ds_valid}, 72'h0);
        idle(1);
        chk("flush+dok drop_cnt", {70'h0, dut.drop_cnt}, 72'h0);
        chk("flush+dok after", {71'h0, fs_to_ds_valid}, 72'h0);

        // exception entry
        step(1, mkps(0, 0, 6'h08, 1, 32'h1c000002), 0, 0, 0, 1);
        idle(1);
        chk("ex valid", {71'h0, fs_to_ds_valid}, 72'h1);
        chk("ex bus", fs_to_ds_bus, {1'b0, 6'h08, 1'b1, 32'h0, 32'h1c000002});

        // async reset with one stale response outstanding
        step(1, mkps(0, 0, 0, 0, 32'h1c000008), 0, 0, 0, 1);
        step(0, 41'h0, 1, 0, 0, 1);
        step(1, mkps(0, 0, 0, 0, 32'h1c000300), 0, 0, 0, 1);
        #2 resetn = 0;
        #1;
        chk("arst fs_to_ds_valid", {71'h0, fs_to_ds_valid}, 72'h0);
        chk("arst fs_allowin", {71'h0, fs_allowin}, 72'h1);
        model_reset();
        ps_to_fs_valid = 0;
        @(posedge clk); #1 resetn = 1;
        #1 chk("arst drop_cnt", {70'h0, dut.drop_cnt}, 72'h0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            psv = ($urandom_range(0, 3) != 0);
            ex  = ($urandom_range(0, 4) == 0);
            psb = mkps(ex & $urandom_range(0, 1), ex & $urandom_range(0, 1),
                       ex ? 6'($urandom_range(0, 63)) : 6'h0, ex, $urandom);
            fl  = ($urandom_range(0, 5) == 0) && (n_stale() < 2);
            dok = (resp_q.size() > 0) && ($urandom_range(0, 2) != 0);
            dsa = ($urandom_range(0, 3) != 0);
            step(psv, psb, fl, dok, $urandom, dsa);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
